spr_dma_engine: RTL and testbench

SPR_DMA_ENGINE -- requirements
Module: spr_dma_engine

---
 rtl/spr_dma_engine_if.sv | 25 ++
 rtl/spr_dma_engine.sv | 147 ++++++++++++++
 tb/tb_spr_dma_engine.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spr_dma_engine_if.sv
// Bus bundle between the sprite DMA engine, the CPU core and the memory subsystem.
// The slave side is the DMA engine; the master side is the surrounding system.
interface spr_dma_engine_if;
    logic [15:0] cpu_addr_out;
    logic [7:0]  cpu_data_out;
    logic        cpu_wen;
    logic        cpu_ren;
    logic [7:0]  cpu_data_in;
    logic        cpu_rdy;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_wen;
    logic        mem_ren;
    logic [7:0]  mem_rdata;

    modport master (
        output cpu_addr_out, cpu_data_out, cpu_wen, cpu_ren, mem_rdata,
        input  cpu_data_in, cpu_rdy, mem_addr, mem_wdata, mem_wen, mem_ren
    );

    modport slave (
        input  cpu_addr_out, cpu_data_out, cpu_wen, cpu_ren, mem_rdata,
        output cpu_data_in, cpu_rdy, mem_addr, mem_wdata, mem_wen, mem_ren
    );
endinterface

// File: rtl/spr_dma_engine.sv
// Sprite DMA: a CPU write to DMA_REG_ADDR copies one 256-byte page into the
// SPR-RAM data register while the CPU is stalled; otherwise the bus passes through.
module spr_dma_engine #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
    input  logic             clk,
    input  logic             rst,
    spr_dma_engine_if.slave  bus,
    output logic             busy,
    output logic             dma_done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALIGN = 2'd1,
        ST_READ  = 2'd2,
        ST_WRITE = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  data_q, data_d;
    logic        parity_q;
    logic        align_q, align_d;
    logic        done_q, done_d;

    logic [15:0] mem_addr_s;
    logic [7:0]  mem_wdata_s;
    logic        mem_wen_s;
    logic        mem_ren_s;
    logic [7:0]  cpu_data_in_s;
    logic        cpu_rdy_s;
    logic        busy_s;

    // State and datapath registers; parity free-runs to pick the ALIGN length.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            page_q   <= 8'h00;
            idx_q    <= 8'h00;
            data_q   <= 8'h00;
            parity_q <= 1'b0;
            align_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            page_q   <= page_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            parity_q <= ~parity_q;
            align_q  <= align_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic and bus steering for each phase of the transfer.
    always_comb begin
        state_d       = state_q;
        page_d        = page_q;
        idx_d         = idx_q;
        data_d        = data_q;
        align_d       = align_q;
        done_d        = 1'b0;
        mem_addr_s    = 16'h0000;
        mem_wdata_s   = 8'h00;
        mem_wen_s     = 1'b0;
        mem_ren_s     = 1'b0;
        cpu_data_in_s = 8'h00;
        cpu_rdy_s     = 1'b0;
        busy_s        = 1'b1;

        case (state_q)
            ST_IDLE: begin
                cpu_rdy_s     = 1'b1;
                busy_s        = 1'b0;
                mem_addr_s    = bus.cpu_addr_out;
                mem_wdata_s   = bus.cpu_data_out;
                mem_wen_s     = bus.cpu_wen;
                mem_ren_s     = bus.cpu_ren;
                cpu_data_in_s = bus.mem_rdata;
                if (bus.cpu_wen && (bus.cpu_addr_out == DMA_REG_ADDR)) begin
                    page_d  = bus.cpu_data_out;
                    idx_d   = 8'h00;
                    align_d = parity_q;
                    state_d = ST_ALIGN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ALIGN: begin
                // A trigger on an odd cycle spends one extra cycle here.
                if (align_q) begin
                    align_d = 1'b0;
                    state_d = ST_ALIGN;
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                mem_addr_s = {page_q, idx_q};
                mem_ren_s  = 1'b1;
                data_d     = bus.mem_rdata;
                state_d    = ST_WRITE;
            end
            ST_WRITE: begin
                mem_addr_s  = OAM_DATA_ADDR;
                mem_wdata_s = data_q;
                mem_wen_s   = 1'b1;
                idx_d       = idx_q + 8'd1;
                if (idx_q == 8'hFF) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_READ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Reset silences the bus immediately, so an aborted transfer emits no further strobes.
        if (rst) begin
            mem_addr_s    = 16'h0000;
            mem_wdata_s   = 8'h00;
            mem_wen_s     = 1'b0;
            mem_ren_s     = 1'b0;
            cpu_data_in_s = 8'h00;
            cpu_rdy_s     = 1'b1;
            busy_s        = 1'b0;
        end else begin
            busy_s        = busy_s;
        end
    end

    assign bus.mem_addr    = mem_addr_s;
    assign bus.mem_wdata   = mem_wdata_s;
    assign bus.mem_wen     = mem_wen_s;
    assign bus.mem_ren     = mem_ren_s;
    assign bus.cpu_data_in = cpu_data_in_s;
    assign bus.cpu_rdy     = cpu_rdy_s;
    assign busy            = busy_s;
    assign dma_done        = done_q & ~rst;

endmodule

// File: tb/tb_spr_dma_engine.sv
// Directed bench for spr_dma_engine: page copies, odd-cycle trigger, top page,
// CPU interference during DMA, mid-transfer reset and idle pass-through.
module tb_spr_dma_engine;

    logic clk;
    logic rst;
    logic busy;
    logic dma_done;

    spr_dma_engine_if bus ();

    spr_dma_engine #(
        .DMA_REG_ADDR  (16'h4014),
        .OAM_DATA_ADDR (16'h2004)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .busy     (busy),
        .dma_done (dma_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: page FF is ROM holding ~low byte, upper half otherwise low byte ^ 5A, lower half low byte.
    always_comb begin
        if (bus.mem_addr[15:8] == 8'hFF) begin
            bus.mem_rdata = ~bus.mem_addr[7:0];
        end else if (bus.mem_addr[15]) begin
            bus.mem_rdata = bus.mem_addr[7:0] ^ 8'h5A;
        end else begin
            bus.mem_rdata = bus.mem_addr[7:0];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    int         wr_cnt;
    int         rd_cnt;
    int         done_cnt;
    logic [7:0] exp_page;
    logic [7:0] rd_idx;
    logic [7:0] exp_data;
    logic [7:0] exp_step;
    logic [15:0] last_rd;

    // Bus monitor: every access while busy must follow the page-copy sequence.
    always @(negedge clk) begin
        if (busy) begin
            check_eq("din_busy", 32'(bus.cpu_data_in), 32'h0);
            if (bus.mem_ren) begin
                check_eq("rd_addr", 32'(bus.mem_addr), 32'({exp_page, rd_idx}));
                last_rd = bus.mem_addr;
                rd_idx  = rd_idx + 8'd1;
                rd_cnt++;
            end
            if (bus.mem_wen) begin
                check_eq("wr_addr", 32'(bus.mem_addr), 32'h2004);
                check_eq("wr_data", 32'(bus.mem_wdata), 32'(exp_data));
                exp_data = exp_data + exp_step;
                wr_cnt++;
            end
        end
        if (dma_done) done_cnt++;
    end

    task automatic idle_bus();
        bus.cpu_addr_out = 16'h0000;
        bus.cpu_data_out = 8'h00;
        bus.cpu_wen      = 1'b0;
        bus.cpu_ren      = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic start_dma(input logic [7:0] page, input int idle_wait,
                             input logic [7:0] d0, input logic [7:0] step);
        wr_cnt   = 0;
        rd_cnt   = 0;
        done_cnt = 0;
        exp_page = page;
        rd_idx   = 8'h00;
        exp_data = d0;
        exp_step = step;
        for (int n = 0; n < idle_wait; n++) @(negedge clk);
        bus.cpu_addr_out = 16'h4014;
        bus.cpu_data_out = page;
        bus.cpu_wen      = 1'b1;
        #1;
        check_eq("trig_wen", 32'(bus.mem_wen), 32'h1);
        check_eq("trig_addr", 32'(bus.mem_addr), 32'h4014);
        check_eq("trig_wdata", 32'(bus.mem_wdata), 32'(page));
        @(posedge clk);
        @(negedge clk);
        idle_bus();
    endtask

    task automatic finish_dma(input int exp_low, input bit disturb, input logic [15:0] exp_last);
        int cnt;
        cnt = 0;
        while (!bus.cpu_rdy && cnt < 600) begin
            cnt++;
            if (disturb && cnt == 10) begin
                bus.cpu_addr_out = 16'h4014;
                bus.cpu_data_out = 8'h55;
                bus.cpu_wen      = 1'b1;
            end
            if (disturb && cnt == 20) bus.cpu_addr_out = 16'h0000;
            if (disturb && cnt == 30) idle_bus();
            @(negedge clk);
        end
        check_eq("rdy_low_cycles", 32'(cnt), 32'(exp_low));
        check_eq("done_pulse", 32'(dma_done), 32'h1);
        check_eq("done_busy", 32'(busy), 32'h0);
        bus.cpu_addr_out = 16'h8001;
        bus.cpu_ren      = 1'b1;
        #1;
        check_eq("done_pt_addr", 32'(bus.mem_addr), 32'h8001);
        check_eq("done_pt_ren", 32'(bus.mem_ren), 32'h1);
        check_eq("done_pt_din", 32'(bus.cpu_data_in), 32'h5B);
        @(negedge clk);
        idle_bus();
        #1;
        check_eq("done_single", 32'(dma_done), 32'h0);
        check_eq("no_restart", 32'(busy), 32'h0);
        check_eq("wr_count", 32'(wr_cnt), 32'd256);
        check_eq("rd_count", 32'(rd_cnt), 32'd256);
        check_eq("done_count", 32'(done_cnt), 32'd1);
        check_eq("last_rd", 32'(last_rd), 32'(exp_last));
    endtask

    initial begin
        int n;
        wr_cnt   = 0;
        rd_cnt   = 0;
        done_cnt = 0;
        exp_page = 8'h00;
        rd_idx   = 8'h00;
        exp_data = 8'h00;
        exp_step = 8'h01;
        last_rd  = 16'h0000;

        // Reset state with the CPU trying to read: everything must stay quiet.
        rst              = 1'b1;
        bus.cpu_addr_out = 16'h8000;
        bus.cpu_data_out = 8'h00;
        bus.cpu_wen      = 1'b0;
        bus.cpu_ren      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        check_eq("rst_rdy", 32'(bus.cpu_rdy), 32'h1);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_done", 32'(dma_done), 32'h0);
        check_eq("rst_ren", 32'(bus.mem_ren), 32'h0);
        check_eq("rst_addr", 32'(bus.mem_addr), 32'h0);
        check_eq("rst_din", 32'(bus.cpu_data_in), 32'h0);

        // Idle pass-through read and write.
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("pt_ren", 32'(bus.mem_ren), 32'h1);
        check_eq("pt_addr", 32'(bus.mem_addr), 32'h8000);
        check_eq("pt_din", 32'(bus.cpu_data_in), 32'h5A);
        check_eq("pt_busy", 32'(busy), 32'h0);
        @(negedge clk);
        bus.cpu_ren      = 1'b0;
        bus.cpu_addr_out = 16'h0123;
        bus.cpu_data_out = 8'hA7;
        bus.cpu_wen      = 1'b1;
        #1;
        check_eq("pt_wen", 32'(bus.mem_wen), 32'h1);
        check_eq("pt_wdata", 32'(bus.mem_wdata), 32'hA7);
        check_eq("pt_waddr", 32'(bus.mem_addr), 32'h0123);
        @(negedge clk);
        idle_bus();
        #1;
        check_eq("pt_busy2", 32'(busy), 32'h0);

        // Even-cycle trigger, page 02.
        do_reset();
        start_dma(8'h02, 0, 8'h00, 8'h01);
        finish_dma(513, 1'b0, 16'h02FF);

        // Odd-cycle trigger, page 02.
        do_reset();
        start_dma(8'h02, 1, 8'h00, 8'h01);
        finish_dma(514, 1'b0, 16'h02FF);

        // Top page: ROM FF00..FFFF, data counts down.
        do_reset();
        start_dma(8'hFF, 0, 8'hFF, 8'hFF);
        finish_dma(513, 1'b0, 16'hFFFF);

        // I/O-mapped page is copied like any other.
        do_reset();
        start_dma(8'h20, 0, 8'h00, 8'h01);
        finish_dma(513, 1'b0, 16'h20FF);

        // CPU writes to the trigger register and to 0000 during the transfer are ignored.
        do_reset();
        start_dma(8'h02, 0, 8'h00, 8'h01);
        finish_dma(513, 1'b1, 16'h02FF);

        // Reset after 100 OAM writes aborts immediately, then a fresh page 03 copy.
        do_reset();
        start_dma(8'h02, 0, 8'h00, 8'h01);
        n = 0;
        while (wr_cnt < 100 && n < 400) begin
            n++;
            @(posedge clk);
        end
        check_eq("abort_reach", 32'(wr_cnt), 32'd100);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("abort_rdy", 32'(bus.cpu_rdy), 32'h1);
        check_eq("abort_busy", 32'(busy), 32'h0);
        check_eq("abort_wen", 32'(bus.mem_wen), 32'h0);
        check_eq("abort_ren", 32'(bus.mem_ren), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("post_rst_busy", 32'(busy), 32'h0);
        check_eq("post_rst_rdy", 32'(bus.cpu_rdy), 32'h1);
        check_eq("post_rst_wen", 32'(bus.mem_wen), 32'h0);
        check_eq("post_rst_ren", 32'(bus.mem_ren), 32'h0);
        check_eq("abort_wr_cnt", 32'(wr_cnt), 32'd100);
        start_dma(8'h03, 0, 8'h00, 8'h01);
        finish_dma(513, 1'b0, 16'h03FF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
